// File: rtl/ps2_scancode_fifo.sv
// PS/2 scan-code-set-2 byte decoder feeding a small event FIFO popped by the 68k bus side.
// Latency: an event is written on the byte-strobe edge and shows at rd_data/empty the next cycle.
// Backpressure: none toward the keyboard; events arriving while full are dropped (sticky overflow).
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   code_data, code_valid  received byte; each rising edge of code_valid is one new byte
//   rd_en                  pop head entry (no effect when empty)
//   rd_data                head entry {brk, ext, code[7:0]}, first-word-fall-through
//   empty, count           FIFO occupancy
//   overflow, kbd_err      sticky flags, cleared by flag_clr (a same-cycle set wins)
//   bat_ok                 one-cycle pulse on keyboard self-test pass (0xAA)
module ps2_scancode_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    code_data,
  input  logic          code_valid,
  input  logic          rd_en,
  output logic [9:0]    rd_data,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          kbd_err,
  output logic          bat_ok,
  input  logic          flag_clr
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_E0   = 3'd1;
  localparam logic [2:0] ST_F0   = 3'd2;
  localparam logic [2:0] ST_E0F0 = 3'd3;
  localparam logic [2:0] ST_SKIP = 3'd4;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [2:0]    state, state_nxt;
  logic [2:0]    skip_cnt, skip_nxt;
  logic          valid_prev;
  logic          new_byte;
  logic          evt_vld;
  logic [9:0]    evt_dat;
  logic          set_err;
  logic          set_bat;
  logic          is_ext;
  logic          is_brk;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;
  logic          ovf_set;

  // code_valid is a level; only its rising edge marks a new byte.
  assign new_byte = code_valid & ~valid_prev;

  assign is_ext = (state == ST_E0) || (state == ST_E0F0);
  assign is_brk = (state == ST_F0) || (state == ST_E0F0);

  // Prefix tracking and event formation for the byte seen this cycle.
  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    evt_vld   = 1'b0;
    evt_dat   = '0;
    set_err   = 1'b0;
    set_bat   = 1'b0;
    if (new_byte) begin
      if (state == ST_SKIP) begin
        // Pause is E1 followed by 7 bytes that carry nothing useful.
        skip_nxt = skip_cnt - 3'd1;
        if (skip_cnt == 3'd1) begin
          state_nxt = ST_IDLE;
        end
      end else begin
        case (code_data)
          8'hE1: begin
            evt_vld   = 1'b1;
            evt_dat   = {2'b01, 8'hE1};
            skip_nxt  = 3'd7;
            state_nxt = ST_SKIP;
          end
          8'hE0: state_nxt = is_brk ? ST_E0F0 : ST_E0;
          8'hF0: state_nxt = is_ext ? ST_E0F0 : ST_F0;
          8'hAA: begin
            set_bat   = 1'b1;
            state_nxt = ST_IDLE;
          end
          8'hFA, 8'hEE, 8'hFE: state_nxt = ST_IDLE;
          8'h00, 8'hFF: begin
            set_err   = 1'b1;
            state_nxt = ST_IDLE;
          end
          default: begin
            evt_vld   = 1'b1;
            evt_dat   = {is_brk, is_ext, code_data};
            state_nxt = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      skip_cnt   <= 3'd0;
      // A level already high through reset must not count as a fresh byte.
      valid_prev <= 1'b1;
      bat_ok     <= 1'b0;
    end else begin
      state      <= state_nxt;
      skip_cnt   <= skip_nxt;
      valid_prev <= code_valid;
      bat_ok     <= set_bat;
    end
  end

  // A pop in the same cycle frees the slot a full FIFO needs for the write.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign rd_ok   = rd_en & ~empty;
  assign wr_ok   = evt_vld & (~full | rd_en);
  assign ovf_set = evt_vld & ~wr_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= evt_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      kbd_err  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Setting events take priority over a same-cycle clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (flag_clr) begin
        overflow <= 1'b0;
      end
      if (set_err) begin
        kbd_err <= 1'b1;
      end else if (flag_clr) begin
        kbd_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Self-checking bench for ps2_scancode_fifo: per-byte vector table with a scoreboard queue,
// plus hand-written sequences for count, overflow, held level, status bytes and reset.
// Inputs are driven on negedge; outputs are sampled on negedge.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    code_data;
  logic          code_valid;
  logic          rd_en;
  logic [9:0]    rd_data;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          kbd_err;
  logic          bat_ok;
  logic          flag_clr;

  int n_vec = 0;
  int n_err = 0;

  logic [9:0] sb[$];

  typedef struct {
    logic [7:0] b;
    logic       push;
    logic [9:0] dat;
  } vec_t;

  vec_t vecs[$];

  ps2_scancode_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_data  (code_data),
    .code_valid (code_valid),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .kbd_err    (kbd_err),
    .bat_ok     (bat_ok),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got still-running need done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] b, input logic push, input logic [9:0] dat);
    vec_t v;
    v.b = b;
    v.push = push;
    v.dat = dat;
    vecs.push_back(v);
  endtask

  // One byte: level high for one posedge, then low for one posedge. Returns on a negedge
  // right after the decode edge has taken effect.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code_data  = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Compare head against the scoreboard, then pop it.
  task automatic pop_head(input string name);
    logic [9:0] exp;
    chk({name, "_nonempty"}, 32'(empty), 32'd0);
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: got entry 0x%0h expected no entry", name, rd_data);
    end else begin
      exp = sb.pop_front();
      chk(name, 32'(rd_data), 32'(exp));
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    code_data  = 8'h00;
    code_valid = 1'b0;
    rd_en      = 1'b0;
    flag_clr   = 1'b0;

    // Per-byte table: {byte, entry expected, entry value {brk,ext,code}}
    add(8'h1C, 1'b1, 10'h01C);
    add(8'hF0, 1'b0, 10'h000); add(8'h1C, 1'b1, 10'h21C);
    add(8'hE0, 1'b0, 10'h000); add(8'h75, 1'b1, 10'h175);
    add(8'hE0, 1'b0, 10'h000); add(8'hF0, 1'b0, 10'h000); add(8'h75, 1'b1, 10'h375);
    add(8'hF0, 1'b0, 10'h000); add(8'hE0, 1'b0, 10'h000); add(8'h6B, 1'b1, 10'h36B);
    add(8'hE1, 1'b1, 10'h1E1);
    add(8'h14, 1'b0, 10'h000); add(8'h77, 1'b0, 10'h000); add(8'hE1, 1'b0, 10'h000);
    add(8'hF0, 1'b0, 10'h000); add(8'h14, 1'b0, 10'h000); add(8'hF0, 1'b0, 10'h000);
    add(8'h77, 1'b0, 10'h000);
    add(8'h1C, 1'b1, 10'h01C);
    add(8'hFA, 1'b0, 10'h000); add(8'h5A, 1'b1, 10'h05A);
    add(8'hEE, 1'b0, 10'h000); add(8'hFE, 1'b0, 10'h000);
    add(8'hE0, 1'b0, 10'h000); add(8'h12, 1'b1, 10'h112);
    add(8'hE0, 1'b0, 10'h000); add(8'hE0, 1'b0, 10'h000); add(8'hF0, 1'b0, 10'h000);
    add(8'hF0, 1'b0, 10'h000); add(8'h12, 1'b1, 10'h312);
    add(8'hF0, 1'b0, 10'h000); add(8'hF0, 1'b0, 10'h000); add(8'hE0, 1'b0, 10'h000);
    add(8'h11, 1'b1, 10'h311);
    add(8'hF0, 1'b0, 10'h000); add(8'hE1, 1'b1, 10'h1E1);
    add(8'h00, 1'b0, 10'h000); add(8'hFF, 1'b0, 10'h000); add(8'hAA, 1'b0, 10'h000);
    add(8'hE1, 1'b0, 10'h000); add(8'hE0, 1'b0, 10'h000); add(8'hF0, 1'b0, 10'h000);
    add(8'h12, 1'b0, 10'h000);
    add(8'h34, 1'b1, 10'h034);

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_kbd_err", 32'(kbd_err), 32'd0);
    chk("rst_bat_ok", 32'(bat_ok), 32'd0);

    // Table-driven decode
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].b);
      if (vecs[i].push) sb.push_back(vecs[i].dat);
      chk("vec_empty", 32'(empty), 32'(sb.size() == 0));
      if (!empty) pop_head("vec_head");
    end
    // Bytes swallowed in the Pause tail must not raise status flags
    chk("skip_no_kbd_err", 32'(kbd_err), 32'd0);

    // Two entries queued, then drained
    send(8'h1C); sb.push_back(10'h01C);
    send(8'hF0);
    send(8'h1C); sb.push_back(10'h21C);
    chk("two_count", 32'(count), 32'd2);
    pop_head("two_head0");
    pop_head("two_head1");
    chk("two_empty", 32'(empty), 32'd1);

    // Pop while empty does nothing; pointers stay consistent
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("empty_rd_count", 32'(count), 32'd0);
    send(8'h2C); sb.push_back(10'h02C);
    pop_head("after_empty_rd");

    // Fill, overflow, then write with simultaneous pop while full
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(16 + i));
      sb.push_back(10'(16 + i));
    end
    chk("full_count", 32'(count), 32'd8);
    chk("full_no_ovf", 32'(overflow), 32'd0);
    send(8'h18);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(rd_data), 32'(sb[0]));
    @(negedge clk);
    code_data  = 8'h19;
    code_valid = 1'b1;
    rd_en      = 1'b1;
    void'(sb.pop_front());
    sb.push_back(10'h019);
    @(negedge clk);
    code_valid = 1'b0;
    rd_en      = 1'b0;
    chk("rdwr_full_count", 32'(count), 32'd8);
    for (int i = 0; i < DEPTH; i++) pop_head("drain");
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Level held high is one byte only
    @(negedge clk);
    code_data  = 8'h2A;
    code_valid = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_count", 32'(count), 32'd1);
    code_valid = 1'b0;
    sb.push_back(10'h02A);
    pop_head("held_head");
    chk("held_empty", 32'(empty), 32'd1);

    // Self-test pass: one-cycle pulse, no entry
    @(negedge clk);
    code_data  = 8'hAA;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    chk("bat_pulse", 32'(bat_ok), 32'd1);
    chk("bat_no_entry", 32'(empty), 32'd1);
    @(negedge clk);
    chk("bat_pulse_end", 32'(bat_ok), 32'd0);

    // Error byte: sticky, cleared, and set wins over a same-cycle clear
    send(8'hFF);
    chk("err_ff", 32'(kbd_err), 32'd1);
    chk("err_no_entry", 32'(empty), 32'd1);
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;
    chk("err_clr", 32'(kbd_err), 32'd0);
    @(negedge clk);
    code_data  = 8'h00;
    code_valid = 1'b1;
    flag_clr   = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    flag_clr   = 1'b0;
    chk("err_set_wins", 32'(kbd_err), 32'd1);
    @(negedge clk); flag_clr = 1'b1;
    @(negedge clk); flag_clr = 1'b0;

    // Reset mid-sequence discards prefix and FIFO contents
    send(8'h33);
    send(8'hE0);
    do_reset();
    chk("midrst_empty", 32'(empty), 32'd1);
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_kbd_err", 32'(kbd_err), 32'd0);
    send(8'h1C); sb.push_back(10'h01C);
    pop_head("midrst_ext_cleared");

    // Level high across reset release is not a new byte
    @(negedge clk);
    code_data  = 8'h55;
    code_valid = 1'b1;
    do_reset();
    repeat (3) @(negedge clk);
    chk("held_thru_rst", 32'(empty), 32'd1);
    code_valid = 1'b0;
    send(8'h4D); sb.push_back(10'h04D);
    pop_head("post_rst_byte");
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
